score_keeper: RTL
=================

Name: score_keeper

Overview:
- Rally/score sequencer. Sits downstream of the ball datapath and upstream of the two hex_decoder score displays and the control FSM's gameover/menu inputs.
- Consumes per-frame ticks, ball-miss pulses and the enter-key pulse.
- Produces both 4-bit scores, the gameover flag, the serve direction, and a ball-enable that gates ball motion during the serve pause.

Parameters:
- WIN_SCORE, 7, points needed to win; legal range 1..15.
- SERVE_FRAMES, 60, frame_tick pulses to wait in SERVE before releasing the ball; legal range 1..255.

Ports:
- clk  input  1  system clock (CLOCK_50 domain)
- resetn  input  1  reset; asynchronous, active-low
- frame_tick  input  1  one-cycle pulse, once per video frame
- left_miss  input  1  one-cycle pulse: ball crossed the left edge (right player scores)
- right_miss  input  1  one-cycle pulse: ball crossed the right edge (left player scores)
- start  input  1  one-cycle pulse from the enter key
- left_score  output  4  left player score
- right_score  output  4  right player score
- ball_enable  output  1  high only in PLAY; the datapath freezes the ball when low
- serving  output  1  high only in SERVE
- serve_dir  output  1  1 = next serve travels right, 0 = left
- gameover  output  1  high only in OVER
- winner  output  1  valid while gameover; 1 = right player won, 0 = left player won

Behaviour:
- All outputs are registered.
- Reset values: state IDLE, scores 0, ball_enable 0, serving 0, serve_dir 1, gameover 0, winner 0, frame counter 0.
- States: IDLE, SERVE, PLAY, POINT, OVER.
- IDLE:
  - Outputs idle; the misses and frame_tick are ignored.
  - start moves to SERVE next cycle; scores are cleared to 0 in the same cycle.
- SERVE:
  - Counts frame_tick pulses in an 8-bit counter, cleared on entry.
  - When the counter reaches SERVE_FRAMES-1 and frame_tick is high, move to PLAY next cycle.
  - Misses and start are ignored.
- PLAY, on a miss:
  - left_miss alone: right_score increments and serve_dir becomes 0 on the next edge (cycle N+1); state becomes POINT.
  - right_miss alone: left_score increments and serve_dir becomes 1 on the next edge (cycle N+1); state becomes POINT.
  - Both misses in the same cycle: no score change, serve_dir unchanged, go directly to SERVE.
  - start is ignored in PLAY.
- POINT (exactly one cycle), using the updated scores:
  - If either score is at least WIN_SCORE, go to OVER; winner = 1 if right_score >= WIN_SCORE.
  - Otherwise go to SERVE.
  - Net effect: gameover or serving is asserted at cycle N+2 after the miss pulse.
- Scores saturate at 15 and never wrap.
- OVER:
  - Scores hold; gameover = 1.
  - start clears the scores, sets serve_dir = 1, clears winner and gameover, and moves to SERVE next cycle.
- A frame_tick coincident with entry into SERVE is not counted.
- resetn asserted in any state returns everything to reset values immediately, with no clock needed.

Optional Feature:
- Macro: SCORE_WIN_BY_TWO_EN.
- When defined, the POINT win test is: (score >= WIN_SCORE and score - other_score >= 2) or score == 15.
  - The lead test uses 5-bit unsigned difference of the two scores.
  - Deuce continues past WIN_SCORE until a 2-point lead or saturation at 15.
  - At 15-15 the player who just scored wins.
- When undefined, the plain first-to-WIN_SCORE rule applies and no difference logic is synthesised.

Test Plan:
- Reset, start pulse, SERVE_FRAMES=4 -> serving=1 for exactly 4 frame_ticks; ball_enable rises the cycle after the 4th tick.
- In PLAY, pulse left_miss at cycle N -> right_score 0->1 and serve_dir=0 at N+1; serving=1 at N+2; ball_enable=0 from N+1.
- In PLAY, left_miss and right_miss in the same cycle -> scores unchanged, serve_dir unchanged, serving=1 next cycle.
- WIN_SCORE=3, left scores 3 unanswered -> gameover=1 and winner=0 two cycles after the third right_miss; further misses ignored; start -> scores 0, serve_dir=1, serving=1.
- With SCORE_WIN_BY_TWO_EN, WIN_SCORE=3, play to 3-3 then 4-3 -> no gameover; next point to 5-3 -> gameover, winner=0. Without the macro, the first to reach 3 ends the game.
- Assert resetn mid-SERVE with counter=2 -> all outputs return to reset values asynchronously; start afterwards restarts a full SERVE_FRAMES count.

Source files
------------

// File: rtl/score_keeper.sv
// Rally/score sequencer: serve pause, point scoring, game-over detection.
// Optional win-by-two deuce rule enabled by defining SCORE_WIN_BY_TWO_EN.
module score_keeper #(
    parameter int unsigned WIN_SCORE    = 7,
    parameter int unsigned SERVE_FRAMES = 60
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       frame_tick,
    input  logic       left_miss,
    input  logic       right_miss,
    input  logic       start,
    output logic [3:0] left_score,
    output logic [3:0] right_score,
    output logic       ball_enable,
    output logic       serving,
    output logic       serve_dir,
    output logic       gameover,
    output logic       winner
);

    localparam int unsigned SCORE_W = 4;
    localparam int unsigned CNT_W   = 8;

    localparam logic [SCORE_W-1:0] WIN_TGT    = SCORE_W'(WIN_SCORE);
    localparam logic [SCORE_W-1:0] SCORE_MAX  = '1;
    localparam logic [CNT_W-1:0]   SERVE_LAST = CNT_W'(SERVE_FRAMES - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_SERVE = 3'd1,
        S_PLAY  = 3'd2,
        S_POINT = 3'd3,
        S_OVER  = 3'd4
    } state_t;

    state_t             state_q, state_d;
    logic [SCORE_W-1:0] left_score_q, left_score_d;
    logic [SCORE_W-1:0] right_score_q, right_score_d;
    logic [CNT_W-1:0]   frame_cnt_q, frame_cnt_d;
    logic               ball_enable_q, ball_enable_d;
    logic               serving_q, serving_d;
    logic               serve_dir_q, serve_dir_d;
    logic               gameover_q, gameover_d;
    logic               winner_q, winner_d;
    logic               left_win_c, right_win_c;

`ifdef SCORE_WIN_BY_TWO_EN
    logic [SCORE_W:0] lead_r_c, lead_l_c;

    // Borrow bit of the 5-bit difference marks a trailing score
    always_comb begin
        lead_r_c    = {1'b0, right_score_q} - {1'b0, left_score_q};
        lead_l_c    = {1'b0, left_score_q} - {1'b0, right_score_q};
        right_win_c = ((right_score_q >= WIN_TGT) && !lead_r_c[SCORE_W]
                       && (lead_r_c[SCORE_W-1:0] >= SCORE_W'(2)))
                      || (right_score_q == SCORE_MAX);
        left_win_c  = ((left_score_q >= WIN_TGT) && !lead_l_c[SCORE_W]
                       && (lead_l_c[SCORE_W-1:0] >= SCORE_W'(2)))
                      || (left_score_q == SCORE_MAX);
    end
`else
    always_comb begin
        right_win_c = (right_score_q >= WIN_TGT);
        left_win_c  = (left_score_q >= WIN_TGT);
    end
`endif

    // State register
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) state_q <= S_IDLE;
        else         state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start) state_d = S_SERVE;
            S_SERVE: if (frame_tick && (frame_cnt_q == SERVE_LAST)) state_d = S_PLAY;
            S_PLAY: begin
                if (left_miss && right_miss)     state_d = S_SERVE;
                else if (left_miss || right_miss) state_d = S_POINT;
            end
            S_POINT: state_d = (left_win_c || right_win_c) ? S_OVER : S_SERVE;
            S_OVER:  if (start) state_d = S_SERVE;
            default: state_d = S_IDLE;
        endcase
    end

    // Datapath and output next values; flags decode the upcoming state
    always_comb begin
        left_score_d  = left_score_q;
        right_score_d = right_score_q;
        serve_dir_d   = serve_dir_q;
        winner_d      = winner_q;
        frame_cnt_d   = '0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    left_score_d  = '0;
                    right_score_d = '0;
                end
            end
            S_SERVE: begin
                frame_cnt_d = frame_tick ? frame_cnt_q + CNT_W'(1) : frame_cnt_q;
            end
            S_PLAY: begin
                if (left_miss && !right_miss) begin
                    right_score_d = (right_score_q == SCORE_MAX) ? right_score_q
                                                                 : right_score_q + SCORE_W'(1);
                    serve_dir_d   = 1'b0;
                end else if (right_miss && !left_miss) begin
                    left_score_d  = (left_score_q == SCORE_MAX) ? left_score_q
                                                                : left_score_q + SCORE_W'(1);
                    serve_dir_d   = 1'b1;
                end
            end
            S_POINT: begin
                // On a double win (15-15) the last scorer takes it; serve_dir points away from them
                if (left_win_c || right_win_c)
                    winner_d = (left_win_c && right_win_c) ? !serve_dir_q : right_win_c;
            end
            S_OVER: begin
                if (start) begin
                    left_score_d  = '0;
                    right_score_d = '0;
                    serve_dir_d   = 1'b1;
                    winner_d      = 1'b0;
                end
            end
            default: ;
        endcase
        ball_enable_d = (state_d == S_PLAY);
        serving_d     = (state_d == S_SERVE);
        gameover_d    = (state_d == S_OVER);
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            left_score_q  <= '0;
            right_score_q <= '0;
            frame_cnt_q   <= '0;
            ball_enable_q <= 1'b0;
            serving_q     <= 1'b0;
            serve_dir_q   <= 1'b1;
            gameover_q    <= 1'b0;
            winner_q      <= 1'b0;
        end else begin
            left_score_q  <= left_score_d;
            right_score_q <= right_score_d;
            frame_cnt_q   <= frame_cnt_d;
            ball_enable_q <= ball_enable_d;
            serving_q     <= serving_d;
            serve_dir_q   <= serve_dir_d;
            gameover_q    <= gameover_d;
            winner_q      <= winner_d;
        end
    end

    assign left_score  = left_score_q;
    assign right_score = right_score_q;
    assign ball_enable = ball_enable_q;
    assign serving     = serving_q;
    assign serve_dir   = serve_dir_q;
    assign gameover    = gameover_q;
    assign winner      = winner_q;

endmodule
